lsu_mem_stage: RTL and testbench
================================

# lsu_mem_stage

Load/store unit for the RISC-V core's memory stage. It consumes the ALU `Result` as the effective address, plus `rs2` store data and the funct3 size code. It drives a single-outstanding request/grant/response data-bus port, and returns a sign- or zero-extended load value to writeback. It stalls the core while an access is in flight.

## Interface
- `ADDR_W`, 32, address width; `bus_addr` is word-aligned, so bits [1:0] are always 0.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: access requested; the core holds this and all request inputs stable until `done`.
- `mem_read` in 1: load request.
- `mem_write` in 1: store request; takes priority if both are high.
- `funct3` in 3: access size and extension code.
- `addr` in ADDR_W: effective address, taken from the ALU `Result`.
- `wdata` in 32: store data (`rs2`).
- `busy` out 1: stall to the core; equals `req_valid & ~done`, combinational.
- `done` out 1: one-cycle completion pulse, registered.
- `rdata` out 32: extended load data, registered.
- `fault` out 1: misaligned access or illegal funct3; valid only when `done`=1.
- `bus_req`, `bus_we` out 1: bus request and write strobe.
- `bus_addr` out ADDR_W: word address sent to the bus.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-aligned store data.
- `bus_gnt` in 1: request accepted by the bus.
- `bus_rvalid` in 1: load response valid.
- `bus_rdata` in 32: load response data.

## Operation
- FSM states are IDLE, REQ, WAIT and DONE.
- **IDLE:** if `req_valid` and (`mem_read` or `mem_write`), capture addr, wdata, funct3 and we.
  - Legal, aligned access: go to REQ.
  - Fault: go to DONE with `fault`=1, and never raise `bus_req`.
  - If neither `mem_read` nor `mem_write` is set, stay in IDLE.
- **REQ:** `bus_req`=1, with addr, we, be and wdata held stable until `bus_gnt` is sampled high.
  - Store granted: go to DONE.
  - Load granted: go to WAIT.
- **WAIT:** on `bus_rvalid`, latch the extended data into `rdata` and go to DONE.
- **DONE:** `done`=1 for exactly one cycle; `req_valid` is ignored; then go to IDLE.
- Legal loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
- Legal stores: SB 000, SH 001, SW 010.
- Any other funct3 value is a fault.
- Misaligned accesses are faults:
  - halfword with `addr[0]`=1;
  - word with `addr[1:0]`≠0.
- Store byte enables and data:
  - SB: `bus_be` = 1<<`addr[1:0]`; `bus_wdata` = `wdata[7:0]` replicated ×4.
  - SH: `bus_be` = 0011 when `addr[1]`=0, 1100 when `addr[1]`=1; `wdata[15:0]` replicated ×2.
  - SW: `bus_be` = 1111; `bus_wdata` = `wdata`.
- Loads always drive `bus_be`=1111 and `bus_we`=0.
- Load extraction:
  - Select the byte or half lane by `addr[1:0]`.
  - LB and LH sign-extend; LBU and LHU zero-extend.
- `rdata` updates only on load completion and holds through stores and faults.
- `bus_rvalid` is ignored outside WAIT, including any stale response that arrives after reset.
- **Reset values:**
  - state = IDLE;
  - `done`, `fault`, `bus_req` and `bus_we` = 0;
  - `bus_addr`, `bus_be`, `bus_wdata` and `rdata` = 0.
- **Reset mid-access:**
  - The next edge forces IDLE; `bus_req` drops immediately.
  - No `done` pulse is produced for the aborted access.

## Timing
- Capture happens in cycle T (IDLE with `req_valid`).
- `bus_req` is high from T+1.
- The grant may arrive in any cycle G ≥ T+1.
- Store: `done` at G+1, for a minimum latency of 2 cycles.
- Load: WAIT starts at G+1; `bus_rvalid` may be sampled in cycle R ≥ G+1; `done` and `rdata` are valid at R+1, for a minimum latency of 3 cycles.
- Fault: `done`=`fault`=1 at T+1.
- Minimum spacing between access starts is one extra cycle after DONE (the return to IDLE).
- `busy` is combinational, so the core stalls in cycle T with no added latency and advances in the `done` cycle.

## Structure
- `lsu_pkg` holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the FSM state enum;
  - the byte-enable width constant.
- One combinational sub-module, `lsu_align`, performs store lane steering and byte-enable generation, plus load extraction and extension, and flags misalignment and illegal funct3.
- The FSM and registers stay in the top module.

## Test plan
- **SW, immediate grant:** SW, addr 0x100, wdata 0xDEADBEEF, `bus_gnt` high at T+1 → `bus_addr` 0x100, `bus_be` 1111, `bus_wdata` 0xDEADBEEF; `done` at T+2 with `fault`=0.
- **LB and LBU:** addr 0x103, `bus_rdata` 0x80FF1234 with rvalid one cycle after grant → LB gives `rdata` 0xFFFFFF80 and LBU gives 0x00000080; `done` at T+3.
- **LHU upper half:** addr 0x002, `bus_rdata` 0x87654321 → `rdata` 0x00008765; the same case as LH gives 0xFFFF8765.
- **SB, delayed grant:** SB, addr 0x202, wdata 0x000000AB, grant delayed 3 cycles → `bus_be` 0100 and `bus_wdata` 0xABABABAB, held stable for 4 cycles; `busy` stays high until `done`.
- **Misaligned and illegal:**
  - LH at addr 0x101 → `done`=`fault`=1 at T+1, `bus_req` never asserted, `rdata` unchanged.
  - funct3 011 on a load → same response.
- **Reset during WAIT:** assert `rst` while in WAIT → next cycle all outputs are at reset values; a later `bus_rvalid` with data 0x12345678 produces no `done` and leaves `rdata` at 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants and types for the load/store unit
// Purpose: funct3 size codes, FSM state encoding and byte-enable width used
//          by lsu_align and lsu_mem_stage.
package lsu_pkg;

    localparam int BE_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane steering, load extraction and access checking
// Purpose: purely combinational datapath helper for lsu_mem_stage.
// Ports:
//   i_funct3, i_addr_lo, i_we  - access size code, byte offset, store flag
//   i_wdata                    - raw store data (rs2)
//   i_bus_rdata                - raw word returned by the bus
//   o_fault                    - misaligned access or illegal funct3
//   o_be, o_bus_wdata          - byte enables and lane-aligned store data
//   o_load_data                - extracted, sign/zero-extended load value
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic            i_we,
    input  logic [31:0]     i_wdata,
    input  logic [31:0]     i_bus_rdata,
    output logic            o_fault,
    output logic [BE_W-1:0] o_be,
    output logic [31:0]     o_bus_wdata,
    output logic [31:0]     o_load_data
);

    logic        w_illegal;
    logic        w_misaligned;
    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Stores only have the signed size codes; loads add the unsigned ones.
    always_comb begin
        w_illegal = 1'b1;
        if (i_we) begin
            if (i_funct3 == F3_B || i_funct3 == F3_H || i_funct3 == F3_W)
                w_illegal = 1'b0;
        end else begin
            if (i_funct3 == F3_B || i_funct3 == F3_H || i_funct3 == F3_W ||
                i_funct3 == F3_BU || i_funct3 == F3_HU)
                w_illegal = 1'b0;
        end
    end

    // funct3[1:0] carries the size for both signed and unsigned codes.
    assign w_misaligned = ((i_funct3[1:0] == 2'b01) && i_addr_lo[0]) ||
                          ((i_funct3[1:0] == 2'b10) && (i_addr_lo != 2'b00));
    assign o_fault = w_illegal || w_misaligned;

    always_comb begin
        o_be        = 4'b1111;
        o_bus_wdata = i_wdata;
        if (i_we) begin
            case (i_funct3)
                F3_B: begin
                    o_be        = 4'b0001 << i_addr_lo;
                    o_bus_wdata = {4{i_wdata[7:0]}};
                end
                F3_H: begin
                    o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                    o_bus_wdata = {2{i_wdata[15:0]}};
                end
                default: begin
                    o_be        = 4'b1111;
                    o_bus_wdata = i_wdata;
                end
            endcase
        end
    end

    assign w_shifted = i_bus_rdata >> {i_addr_lo, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = i_addr_lo[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];

    always_comb begin
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_BU:   o_load_data = {24'd0, w_byte};
            F3_HU:   o_load_data = {16'd0, w_half};
            default: o_load_data = i_bus_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - memory-stage load/store unit with single-outstanding bus port
// Purpose: accepts one load/store from the core, runs it on a req/gnt/rvalid
//          bus, returns extended load data and stalls the core meanwhile.
// Ports:
//   i_clk, i_rst                       - clock, synchronous active-high reset
//   i_req_valid, i_mem_read, i_mem_write, i_funct3, i_addr, i_wdata - core request
//   o_busy, o_done, o_rdata, o_fault   - stall, completion pulse, load data, fault
//   o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata - bus request side
//   i_bus_gnt, i_bus_rvalid, i_bus_rdata                   - bus grant/response
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic [31:0]       o_rdata,
    output logic              o_fault,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [BE_W-1:0]   o_bus_be,
    output logic [31:0]       o_bus_wdata,
    input  logic              i_bus_gnt,
    input  logic              i_bus_rvalid,
    input  logic [31:0]       i_bus_rdata
);

    lsu_state_e        r_state;
    logic [1:0]        r_addr_lo;
    logic [2:0]        r_funct3;
    logic              r_we;
    logic              r_done;
    logic              r_fault;
    logic [31:0]       r_rdata;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [BE_W-1:0]   r_bus_be;
    logic [31:0]       r_bus_wdata;

    logic              w_idle;
    logic              w_start;
    logic [2:0]        w_funct3;
    logic [1:0]        w_addr_lo;
    logic              w_we;
    logic              w_fault;
    logic [BE_W-1:0]   w_be;
    logic [31:0]       w_bus_wdata;
    logic [31:0]       w_load_data;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_start = i_req_valid && (i_mem_read || i_mem_write);

    // The aligner sees live inputs while deciding at capture, then the
    // captured copy so load extraction does not depend on the core's inputs.
    assign w_funct3  = w_idle ? i_funct3    : r_funct3;
    assign w_addr_lo = w_idle ? i_addr[1:0] : r_addr_lo;
    assign w_we      = w_idle ? i_mem_write : r_we;

    lsu_align u_align (
        .i_funct3    (w_funct3),
        .i_addr_lo   (w_addr_lo),
        .i_we        (w_we),
        .i_wdata     (i_wdata),
        .i_bus_rdata (i_bus_rdata),
        .o_fault     (w_fault),
        .o_be        (w_be),
        .o_bus_wdata (w_bus_wdata),
        .o_load_data (w_load_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_addr_lo   <= 2'b00;
            r_funct3    <= 3'b000;
            r_we        <= 1'b0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
            r_rdata     <= 32'd0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_addr_lo <= i_addr[1:0];
                        r_funct3  <= i_funct3;
                        r_we      <= i_mem_write;
                        if (w_fault) begin
                            // Faulting accesses never touch the bus.
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_fault <= 1'b1;
                        end else begin
                            r_state     <= ST_REQ;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= i_mem_write;
                            r_bus_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
                            r_bus_be    <= w_be;
                            r_bus_wdata <= w_bus_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    if (i_bus_gnt) begin
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        if (r_we) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (i_bus_rvalid) begin
                        r_rdata <= w_load_data;
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_fault <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy      = i_req_valid && !r_done;
    assign o_done      = r_done;
    assign o_fault     = r_fault;
    assign o_rdata     = r_rdata;
    assign o_bus_req   = r_bus_req;
    assign o_bus_we    = r_bus_we;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_be    = r_bus_be;
    assign o_bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - self-checking bench for lsu_mem_stage
module tb_lsu_mem_stage;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid, i_mem_read, i_mem_write;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_wdata;
    logic        o_busy, o_done, o_fault;
    logic [31:0] o_rdata;
    logic        o_bus_req, o_bus_we;
    logic [31:0] o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        i_bus_gnt, i_bus_rvalid;
    logic [31:0] i_bus_rdata;

    always #5 i_clk = ~i_clk;

    lsu_mem_stage #(.ADDR_W(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_busy(o_busy), .o_done(o_done), .o_rdata(o_rdata), .o_fault(o_fault),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
        .o_bus_be(o_bus_be), .o_bus_wdata(o_bus_wdata),
        .i_bus_gnt(i_bus_gnt), .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bus_rd;
        int          gd;
        int          rd;
        logic        exp_fault;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        int          lat;
    } sb_t;

    vec_t        vecs[14];
    sb_t         sb_q[$];
    logic [31:0] model_rdata;
    int          checks = 0;
    int          failures = 0;

    function automatic vec_t mk(logic wr, logic [2:0] f3, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] bus_rd, int gd, int rd,
                                logic ef, logic [3:0] be, logic [31:0] wd,
                                logic [31:0] er, int lat);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.bus_rd = bus_rd;
        v.gd = gd; v.rd = rd; v.exp_fault = ef; v.exp_be = be; v.exp_wd = wd;
        v.exp_rdata = er; v.exp_lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_req_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
        i_funct3 = 3'b000; i_addr = 32'd0; i_wdata = 32'd0;
        i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = 32'd0;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        sb_t  e;
        sb_t  got;
        int   c;
        int   req_cnt;
        int   wait_cnt;
        bit   granted;
        bit   seen;
        v = vecs[idx];
        i_req_valid = 1'b1;
        i_mem_read  = ~v.wr;
        i_mem_write = v.wr;
        i_funct3    = v.f3;
        i_addr      = v.addr;
        i_wdata     = v.wdata;
        e.fault = v.exp_fault;
        e.rdata = (v.wr || v.exp_fault) ? model_rdata : v.exp_rdata;
        e.lat   = v.exp_lat;
        model_rdata = e.rdata;
        sb_q.push_back(e);
        c = 0; req_cnt = 0; wait_cnt = 0; granted = 0; seen = 0;
        while (!seen && c < 60) begin
            @(negedge i_clk);
            c++;
            if (o_done) begin
                seen = 1;
                got = sb_q.pop_front();
                chk($sformatf("v%0d fault", idx), {31'd0, o_fault}, {31'd0, got.fault});
                chk($sformatf("v%0d rdata", idx), o_rdata, got.rdata);
                chk($sformatf("v%0d latency", idx), c, got.lat);
                chk($sformatf("v%0d busy_at_done", idx), {31'd0, o_busy}, 32'd0);
                chk($sformatf("v%0d bus_req_at_done", idx), {31'd0, o_bus_req}, 32'd0);
                idle_inputs();
            end else begin
                chk($sformatf("v%0d busy", idx), {31'd0, o_busy}, 32'd1);
                i_bus_gnt = 1'b0;
                i_bus_rvalid = 1'b0;
                i_bus_rdata = 32'd0;
                if (granted && !v.wr) begin
                    if (wait_cnt == v.rd) begin
                        i_bus_rvalid = 1'b1;
                        i_bus_rdata  = v.bus_rd;
                    end
                    wait_cnt++;
                end
                if (o_bus_req) begin
                    if (v.exp_fault) chk($sformatf("v%0d bus_req_on_fault", idx), 32'd1, 32'd0);
                    chk($sformatf("v%0d bus_addr", idx), o_bus_addr, v.addr & 32'hFFFF_FFFC);
                    chk($sformatf("v%0d bus_be", idx), {28'd0, o_bus_be}, {28'd0, v.exp_be});
                    chk($sformatf("v%0d bus_we", idx), {31'd0, o_bus_we}, {31'd0, v.wr});
                    if (v.wr) chk($sformatf("v%0d bus_wdata", idx), o_bus_wdata, v.exp_wd);
                    if (req_cnt == v.gd) begin
                        i_bus_gnt = 1'b1;
                        granted = 1;
                    end
                    req_cnt++;
                end
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL v%0d timeout: no done within %0d cycles", idx, c);
            void'(sb_q.pop_front());
            idle_inputs();
        end
        @(negedge i_clk);
        chk($sformatf("v%0d done_one_cycle", idx), {31'd0, o_done}, 32'd0);
    endtask

    initial begin
        //        wr    f3      addr           wdata          bus_rdata      gd rd flt be       bus_wdata      rdata          lat
        vecs[0]  = mk(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         0, 0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0,         2);
        vecs[1]  = mk(1'b0, 3'b000, 32'h0000_0103, 32'h0,         32'h80FF_1234, 0, 0, 1'b0, 4'b1111, 32'h0,         32'hFFFF_FF80, 3);
        vecs[2]  = mk(1'b0, 3'b100, 32'h0000_0103, 32'h0,         32'h80FF_1234, 0, 0, 1'b0, 4'b1111, 32'h0,         32'h0000_0080, 3);
        vecs[3]  = mk(1'b0, 3'b101, 32'h0000_0002, 32'h0,         32'h8765_4321, 0, 0, 1'b0, 4'b1111, 32'h0,         32'h0000_8765, 3);
        vecs[4]  = mk(1'b0, 3'b001, 32'h0000_0002, 32'h0,         32'h8765_4321, 0, 0, 1'b0, 4'b1111, 32'h0,         32'hFFFF_8765, 3);
        vecs[5]  = mk(1'b1, 3'b000, 32'h0000_0202, 32'h0000_00AB, 32'h0,         3, 0, 1'b0, 4'b0100, 32'hABAB_ABAB, 32'h0,         5);
        vecs[6]  = mk(1'b0, 3'b001, 32'h0000_0101, 32'h0,         32'h0,         0, 0, 1'b1, 4'b1111, 32'h0,         32'h0,         1);
        vecs[7]  = mk(1'b0, 3'b011, 32'h0000_0100, 32'h0,         32'h0,         0, 0, 1'b1, 4'b1111, 32'h0,         32'h0,         1);
        vecs[8]  = mk(1'b1, 3'b001, 32'h0000_0006, 32'h1234_CAFE, 32'h0,         1, 0, 1'b0, 4'b1100, 32'hCAFE_CAFE, 32'h0,         3);
        vecs[9]  = mk(1'b0, 3'b010, 32'h0000_0040, 32'h0,         32'h0BAD_F00D, 2, 2, 1'b0, 4'b1111, 32'h0,         32'h0BAD_F00D, 7);
        vecs[10] = mk(1'b1, 3'b010, 32'h0000_0102, 32'h1111_1111, 32'h0,         0, 0, 1'b1, 4'b1111, 32'h0,         32'h0,         1);
        vecs[11] = mk(1'b1, 3'b100, 32'h0000_0100, 32'h2222_2222, 32'h0,         0, 0, 1'b1, 4'b1111, 32'h0,         32'h0,         1);
        vecs[12] = mk(1'b0, 3'b000, 32'h0000_0001, 32'h0,         32'h0000_7F00, 1, 1, 1'b0, 4'b1111, 32'h0,         32'h0000_007F, 5);
        vecs[13] = mk(1'b0, 3'b101, 32'h0000_0000, 32'h0,         32'h1234_ABCD, 0, 0, 1'b0, 4'b1111, 32'h0,         32'h0000_ABCD, 3);

        model_rdata = 32'd0;
        idle_inputs();
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("reset done", {31'd0, o_done}, 32'd0);
        chk("reset fault", {31'd0, o_fault}, 32'd0);
        chk("reset bus_req", {31'd0, o_bus_req}, 32'd0);
        chk("reset bus_we", {31'd0, o_bus_we}, 32'd0);
        chk("reset bus_addr", o_bus_addr, 32'd0);
        chk("reset bus_be", {28'd0, o_bus_be}, 32'd0);
        chk("reset bus_wdata", o_bus_wdata, 32'd0);
        chk("reset rdata", o_rdata, 32'd0);
        chk("reset busy", {31'd0, o_busy}, 32'd0);

        // Stale response while idle must be ignored.
        i_bus_rvalid = 1'b1; i_bus_rdata = 32'h1234_5678;
        repeat (2) begin
            @(negedge i_clk);
            chk("stale rvalid done", {31'd0, o_done}, 32'd0);
            chk("stale rvalid rdata", o_rdata, 32'd0);
        end
        idle_inputs();

        // req_valid without read or write must not start an access.
        i_req_valid = 1'b1;
        repeat (2) begin
            @(negedge i_clk);
            chk("no-op bus_req", {31'd0, o_bus_req}, 32'd0);
            chk("no-op done", {31'd0, o_done}, 32'd0);
        end
        idle_inputs();
        @(negedge i_clk);

        for (int i = 0; i < 14; i++) run_vec(i);

        // Reset while waiting for a load response.
        i_req_valid = 1'b1; i_mem_read = 1'b1; i_funct3 = 3'b010; i_addr = 32'h10;
        @(negedge i_clk);
        chk("rstwait bus_req", {31'd0, o_bus_req}, 32'd1);
        i_bus_gnt = 1'b1;
        @(negedge i_clk);
        i_bus_gnt = 1'b0;
        chk("rstwait in wait", {31'd0, o_bus_req | o_done}, 32'd0);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("rstwait done", {31'd0, o_done}, 32'd0);
        chk("rstwait fault", {31'd0, o_fault}, 32'd0);
        chk("rstwait bus_req", {31'd0, o_bus_req}, 32'd0);
        chk("rstwait bus_addr", o_bus_addr, 32'd0);
        chk("rstwait bus_be", {28'd0, o_bus_be}, 32'd0);
        chk("rstwait rdata", o_rdata, 32'd0);
        i_rst = 1'b0;
        idle_inputs();
        @(negedge i_clk);
        i_bus_rvalid = 1'b1; i_bus_rdata = 32'h1234_5678;
        @(negedge i_clk);
        i_bus_rvalid = 1'b0;
        repeat (3) begin
            chk("post-reset rvalid done", {31'd0, o_done}, 32'd0);
            chk("post-reset rvalid rdata", o_rdata, 32'd0);
            @(negedge i_clk);
        end

        chk("scoreboard empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
